// File: rtl/core_wb_bridge_pkg.sv
// core_wb_bridge_pkg
//   Shared types and constants for the Ibex-to-Wishbone bridge.
//   - bridge_state_e  : FSM states (IDLE, REQ, WAIT)
//   - TO_CNT_W        : width of the bus-timeout watchdog counter
//   - WORD_ALIGN_MASK : clears the byte offset of a core address
package core_wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no transaction; core may be granted
        REQ  = 2'd1,  // strobe presented, waiting for stall to drop
        WAIT = 2'd2   // strobe accepted, waiting for ack/err/timeout
    } bridge_state_e;

    localparam int unsigned TO_CNT_W = 16;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage : core_wb_bridge_pkg

// File: rtl/core_wb_bridge.sv
// core_wb_bridge
//   Converts the Ibex data-side req/gnt/rvalid protocol into a single
//   Wishbone B4 pipelined master port. One transaction is in flight at a
//   time; a watchdog turns a missing ack/err into an error response.
//
// Parameters
//   TIMEOUT_CYCLES : cycles from grant until a missing ack/err becomes an
//                    error response (2..65535, 0 disables the watchdog).
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   data_req_i/gnt_o      : core request / combinational grant
//   data_rvalid_o         : registered one-cycle response pulse
//   data_we_i/be_i/addr_i/wdata_i : core request payload
//   data_rdata_o/err_o    : response payload, valid with rvalid
//   wb_cyc_o/stb_o/we_o   : Wishbone cycle, strobe, write enable
//   wb_addr_o/sel_o/data_o: Wishbone address, byte selects, write data
//   wb_data_i             : Wishbone read data
//   wb_ack_i/err_i/stall_i: Wishbone responses
module core_wb_bridge
    import core_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_addr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    // Watchdog fires when the counter sits at TIMEOUT_CYCLES-1; guarded so a
    // zero parameter does not underflow.
    localparam bit                  TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_EN ? TO_CNT_W'(TIMEOUT_CYCLES - 1)
                                                    : '0;

    bridge_state_e       state_q,  state_d;
    logic                we_q,     we_d;
    logic [3:0]          be_q,     be_d;
    logic [31:0]         addr_q,   addr_d;
    logic [31:0]         wdata_q,  wdata_d;
    logic [TO_CNT_W-1:0] cnt_q,    cnt_d;
    logic                rvalid_q, rvalid_d;
    logic [31:0]         rdata_q,  rdata_d;
    logic                err_q,    err_d;

    logic gnt;
    logic timeout;
    logic [TO_CNT_W-1:0] cnt_inc;

    assign timeout = TO_EN && (cnt_q == TO_LAST);
    // Saturating increment so a disabled watchdog never wraps.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TO_CNT_W'(1);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        gnt      = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt = data_req_i;
                if (data_req_i) begin
                    we_d    = data_we_i;
                    be_d    = data_be_i;
                    addr_d  = data_addr_i & WORD_ALIGN_MASK;
                    wdata_d = data_wdata_i;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end

            REQ: begin
                // ack/err are not meaningful before the strobe is accepted.
                cnt_d = cnt_inc;
                if (timeout) begin
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else if (!wb_stall_i) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                cnt_d = cnt_inc;
                if (wb_ack_i || wb_err_i) begin
                    rvalid_d = 1'b1;
                    rdata_d  = we_q ? 32'h0 : wb_data_i;
                    // ack wins over a simultaneous err.
                    err_d    = wb_err_i & ~wb_ack_i;
                    state_d  = IDLE;
                end else if (timeout) begin
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled at the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Reset also clears the payload latches because they drive the
            // Wishbone outputs directly and must read 0 out of reset.
            state_q  <= IDLE;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Grant is combinational but must not escape while reset is asserted.
    assign data_gnt_o    = gnt & ~rst_i;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;

    assign wb_cyc_o  = (state_q != IDLE);
    assign wb_stb_o  = (state_q == REQ);
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_sel_o  = be_q;
    assign wb_data_o = wdata_q;

endmodule : core_wb_bridge

// File: tb/tb_core_wb_bridge.sv
// tb_core_wb_bridge
//   Directed, table-driven bench for core_wb_bridge (TIMEOUT_CYCLES = 8).
//   Inputs are driven 1 ns after the rising edge, outputs sampled 2 ns after.
module tb_core_wb_bridge;

    localparam int unsigned TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_addr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_stall_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    core_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_req_i   (data_req_i),
        .data_gnt_o   (data_gnt_o),
        .data_rvalid_o(data_rvalid_o),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_err_o   (data_err_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_addr_o    (wb_addr_o),
        .wb_sel_o     (wb_sel_o),
        .wb_data_o    (wb_data_o),
        .wb_data_i    (wb_data_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_stall_i   (wb_stall_i)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        int          delay;
        logic        ack;
        logic        err;
        logic [31:0] sdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt"},    32'(data_gnt_o),    32'h0);
        check({tag, " rvalid"}, 32'(data_rvalid_o), 32'h0);
        check({tag, " rdata"},  data_rdata_o,       32'h0);
        check({tag, " err"},    32'(data_err_o),    32'h0);
        check({tag, " cyc"},    32'(wb_cyc_o),      32'h0);
        check({tag, " stb"},    32'(wb_stb_o),      32'h0);
        check({tag, " we"},     32'(wb_we_o),       32'h0);
        check({tag, " addr"},   wb_addr_o,          32'h0);
        check({tag, " sel"},    32'(wb_sel_o),      32'h0);
        check({tag, " data_o"}, wb_data_o,          32'h0);
    endtask

    // Present a request in the current cycle and expect an immediate grant.
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        #1;
        check({tag, " gnt"}, 32'(data_gnt_o), 32'h1);
    endtask

    // Run the bus side of a granted transfer through to its rvalid cycle.
    task automatic complete(input vec_t v, input string tag);
        @(posedge clk_i); #1;
        data_req_i = 1'b0;
        wb_stall_i = (v.stall > 0);
        #1;
        check({tag, " stb"},    32'(wb_stb_o),      32'h1);
        check({tag, " cyc"},    32'(wb_cyc_o),      32'h1);
        check({tag, " addr"},   wb_addr_o,          v.exp_addr);
        check({tag, " sel"},    32'(wb_sel_o),      32'(v.exp_sel));
        check({tag, " we"},     32'(wb_we_o),       32'(v.we));
        check({tag, " data_o"}, wb_data_o,          v.wdata);
        check({tag, " gnt busy"}, 32'(data_gnt_o),  32'h0);
        for (int s = 1; s <= v.stall; s++) begin
            @(posedge clk_i); #1;
            wb_stall_i = (s < v.stall);
            #1;
            check({tag, " stb stalled"},  32'(wb_stb_o), 32'h1);
            check({tag, " addr stalled"}, wb_addr_o,     v.exp_addr);
        end
        for (int d = 0; d <= v.delay; d++) begin
            @(posedge clk_i); #1;
            wb_stall_i = 1'b0;
            if (d == v.delay) begin
                wb_ack_i  = v.ack;
                wb_err_i  = v.err;
                wb_data_i = v.sdata;
            end
            #1;
            check({tag, " wait cyc"},    32'(wb_cyc_o),      32'h1);
            check({tag, " wait stb"},    32'(wb_stb_o),      32'h0);
            check({tag, " wait addr"},   wb_addr_o,          v.exp_addr);
            check({tag, " wait rvalid"}, 32'(data_rvalid_o), 32'h0);
        end
        @(posedge clk_i); #1;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_data_i = 32'h5A5A_1234;
        #1;
        check({tag, " rvalid"},   32'(data_rvalid_o), 32'h1);
        check({tag, " rdata"},    data_rdata_o,       v.exp_rdata);
        check({tag, " err"},      32'(data_err_o),    32'(v.exp_err));
        check({tag, " cyc done"}, 32'(wb_cyc_o),      32'h0);
    endtask

    // Next cycle must not repeat the response.
    task automatic check_no_repeat(input string tag);
        @(posedge clk_i); #1; #1;
        check({tag, " rvalid pulse"}, 32'(data_rvalid_o), 32'h0);
    endtask

    initial begin
        vec_t v;

        //          we    be     addr          wdata         st dl ack   err   sdata         exp_rdata     e     exp_addr      sel
        vecs[0] = '{1'b0, 4'hF, 32'h0000_1004, 32'h0,        0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0000_1004, 4'hF};
        vecs[1] = '{1'b1, 4'h3, 32'h0000_2003, 32'hA5A5_0000, 3, 0, 1'b1, 1'b0, 32'h1234_5678, 32'h0,        1'b0, 32'h0000_2000, 4'h3};
        vecs[2] = '{1'b0, 4'h1, 32'h0000_3008, 32'h0,        1, 2, 1'b0, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 32'h0000_3008, 4'h1};
        vecs[3] = '{1'b0, 4'hC, 32'h0000_400E, 32'h0,        0, 1, 1'b1, 1'b1, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0, 32'h0000_400C, 4'hC};
        vecs[4] = '{1'b1, 4'h6, 32'h0000_5001, 32'h0F0F_F0F0, 2, 1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0,        1'b1, 32'h0000_5000, 4'h6};

        rst_i        = 1'b1;
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'hF;
        data_addr_i  = 32'hFFFF_FFFF;
        data_wdata_i = 32'hFFFF_FFFF;
        wb_data_i    = 32'h0;
        wb_ack_i     = 1'b0;
        wb_err_i     = 1'b0;
        wb_stall_i   = 1'b0;

        // Reset state, with a request pending to exercise grant gating.
        repeat (3) @(posedge clk_i);
        #1; #1;
        check_all_zero("reset");
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        data_req_i = 1'b0;
        #1;

        // Table-driven transfers.
        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(posedge clk_i); #1;
            issue(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, tag);
            complete(vecs[i], tag);
            check_no_repeat(tag);
        end

        // Bus error followed by a request granted in the rvalid cycle.
        v = '{1'b0, 4'hF, 32'h0000_9000, 32'h0, 0, 0, 1'b0, 1'b1, 32'h7777_7777,
              32'h7777_7777, 1'b1, 32'h0000_9000, 4'hF};
        @(posedge clk_i); #1;
        issue(v.we, v.be, v.addr, v.wdata, "b2b0");
        complete(v, "b2b0");
        check("b2b rvalid same cycle", 32'(data_rvalid_o), 32'h1);
        issue(1'b0, 4'hF, 32'h0000_9104, 32'h0, "b2b1");
        v = '{1'b0, 4'hF, 32'h0000_9104, 32'h0, 0, 0, 1'b1, 1'b0, 32'h1357_9BDF,
              32'h1357_9BDF, 1'b0, 32'h0000_9104, 4'hF};
        complete(v, "b2b1");
        check_no_repeat("b2b1");

        // Reset in WAIT abandons the transfer; the later ack is ignored.
        @(posedge clk_i); #1;
        issue(1'b1, 4'hA, 32'h0000_7010, 32'h2468_ACE0, "rst");
        @(posedge clk_i); #1;
        data_req_i = 1'b0;
        #1;
        check("rst stb", 32'(wb_stb_o), 32'h1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        check("rst pre cyc", 32'(wb_cyc_o), 32'h1);
        @(posedge clk_i); #1;
        data_req_i = 1'b1;
        #1;
        check_all_zero("rst mid");
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        data_req_i = 1'b0;
        wb_ack_i   = 1'b1;
        wb_data_i  = 32'h3333_3333;
        #1;
        check("rst late ack cyc", 32'(wb_cyc_o), 32'h0);
        @(posedge clk_i); #1;
        wb_ack_i = 1'b0;
        #1;
        check("rst late ack rvalid", 32'(data_rvalid_o), 32'h0);
        v = '{1'b0, 4'hF, 32'h0000_8000, 32'h0, 0, 0, 1'b1, 1'b0, 32'h8765_4321,
              32'h8765_4321, 1'b0, 32'h0000_8000, 4'hF};
        @(posedge clk_i); #1;
        issue(v.we, v.be, v.addr, v.wdata, "post rst");
        complete(v, "post rst");
        check_no_repeat("post rst");

        // Timeout: slave never answers; error response at T+9.
        @(posedge clk_i); #1;
        issue(1'b0, 4'hF, 32'h0000_6000, 32'h0, "to");
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_i); #1;
            data_req_i = (k == 3);
            #1;
            check($sformatf("to cyc T+%0d", k),    32'(wb_cyc_o),      32'h1);
            check($sformatf("to rvalid T+%0d", k), 32'(data_rvalid_o), 32'h0);
            check($sformatf("to stb T+%0d", k),    32'(wb_stb_o),      (k == 1) ? 32'h1 : 32'h0);
            if (k == 3) check("to gnt in WAIT", 32'(data_gnt_o), 32'h0);
        end
        @(posedge clk_i); #1; #1;
        check("to rvalid", 32'(data_rvalid_o), 32'h1);
        check("to err",    32'(data_err_o),    32'h1);
        check("to rdata",  data_rdata_o,       32'h0);
        check("to cyc",    32'(wb_cyc_o),      32'h0);
        check("to stb",    32'(wb_stb_o),      32'h0);
        for (int k = 10; k <= 13; k++) begin
            @(posedge clk_i); #1;
            wb_ack_i  = (k == 12);
            wb_data_i = 32'h1111_1111;
            #1;
            check($sformatf("to late rvalid T+%0d", k), 32'(data_rvalid_o), 32'h0);
            check($sformatf("to late cyc T+%0d", k),    32'(wb_cyc_o),      32'h0);
        end
        wb_ack_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_core_wb_bridge
